// File: rtl/mem_read_arbiter.sv
// Two-port round-robin arbiter for the single memory read port, with one-cycle
// issue, hold-until-done address, latched response data and a sticky timeout.
module mem_read_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  input  logic        req1_valid,
  input  logic [15:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [15:0] rsp_header,
  output logic [15:0] rsp_car,
  output logic [15:0] rsp_cdr,
  output logic        mem_read_enable,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_header,
  input  logic [15:0] mem_car,
  input  logic [15:0] mem_cdr,
  input  logic        mem_done,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_err
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hdr_q, hdr_d;
  logic [15:0] car_q, car_d;
  logic [15:0] cdr_q, cdr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      hdr_q   <= '0;
      car_q   <= '0;
      cdr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      car_q   <= car_d;
      cdr_q   <= cdr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    grant_d         = grant_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    hdr_d           = hdr_q;
    car_d           = car_q;
    cdr_d           = cdr_q;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    rsp0_valid      = 1'b0;
    rsp1_valid      = 1'b0;
    mem_read_enable = 1'b0;

    case (state_q)
      S_IDLE: begin
        // On a tie, port 0 wins only if port 1 had the previous grant.
        if (req0_valid && (!req1_valid || last_q)) begin
          req0_ready = 1'b1;
          addr_d     = req0_addr;
          grant_d    = 1'b0;
          last_d     = 1'b0;
          state_d    = S_ISSUE;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
          addr_d     = req1_addr;
          grant_d    = 1'b1;
          last_d     = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_read_enable = 1'b1;
        // A same-cycle done skips WAIT, so the data is captured here instead.
        if (mem_done) begin
          hdr_d   = mem_header;
          car_d   = mem_car;
          cdr_d   = mem_cdr;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_done) begin
          hdr_d   = mem_header;
          car_d   = mem_car;
          cdr_d   = mem_cdr;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TIMEOUT_LIMIT) begin
            state_d = S_ERROR;
          end
        end
      end
      S_RESP: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
        cnt_d      = '0;
        state_d    = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr    = addr_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_q;
  assign timeout_err = (state_q == S_ERROR);
  assign rsp_header  = hdr_q;
  assign rsp_car     = car_q;
  assign rsp_cdr     = cdr_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: a per-cycle vector table plus hand-written
// sequences for timeout/ERROR, reset mid-transaction and response data capture.
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_addr, req1_addr;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp_header, rsp_car, rsp_cdr;
  logic        mem_read_enable;
  logic [15:0] mem_addr;
  logic [15:0] mem_header, mem_car, mem_cdr;
  logic        mem_done;
  logic        busy, grant_id, timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mem_read_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_valid      (req0_valid),
    .req0_addr       (req0_addr),
    .req0_ready      (req0_ready),
    .rsp0_valid      (rsp0_valid),
    .req1_valid      (req1_valid),
    .req1_addr       (req1_addr),
    .req1_ready      (req1_ready),
    .rsp1_valid      (rsp1_valid),
    .rsp_header      (rsp_header),
    .rsp_car         (rsp_car),
    .rsp_cdr         (rsp_cdr),
    .mem_read_enable (mem_read_enable),
    .mem_addr        (mem_addr),
    .mem_header      (mem_header),
    .mem_car         (mem_car),
    .mem_cdr         (mem_cdr),
    .mem_done        (mem_done),
    .busy            (busy),
    .grant_id        (grant_id),
    .timeout_err     (timeout_err)
  );

  // Flag order: r0_ready r1_ready rsp0 rsp1 read_enable busy grant_id timeout_err
  typedef struct {
    logic        r0v;
    logic [15:0] r0a;
    logic        r1v;
    logic [15:0] r1a;
    logic        done;
    logic [7:0]  flags;
    logic [15:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(input logic r0v, input logic [15:0] r0a,
                               input logic r1v, input logic [15:0] r1a,
                               input logic done, input logic [7:0] flags,
                               input logic [15:0] addr);
    vec_t v;
    v.r0v = r0v; v.r0a = r0a; v.r1v = r1v; v.r1a = r1a;
    v.done = done; v.flags = flags; v.addr = addr;
    return v;
  endfunction

  function automatic logic [23:0] outs();
    return {req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_read_enable,
            busy, grant_id, timeout_err, mem_addr};
  endfunction

  task automatic chk(input string name, input logic [23:0] exp);
    logic [23:0] got;
    got = outs();
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: outputs(r0rdy r1rdy rsp0 rsp1 re busy gid err|addr) got=%b|%h want=%b|%h",
               name, got[23:16], got[15:0], exp[23:16], exp[15:0]);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r0v, input logic [15:0] r0a,
                       input logic r1v, input logic [15:0] r1a, input logic done);
    req0_valid = r0v; req0_addr = r0a;
    req1_valid = r1v; req1_addr = r1a;
    mem_done   = done;
  endtask

  // Drive at the falling edge, compare 1 ns later, well away from the rising edge.
  task automatic step(input string name, input logic r0v, input logic [15:0] r0a,
                      input logic r1v, input logic [15:0] r1a, input logic done,
                      input logic [7:0] flags, input logic [15:0] addr);
    @(negedge clk);
    drive(r0v, r0a, r1v, r1a, done);
    #1;
    chk(name, {flags, addr});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    mem_header = 16'h0001;
    mem_car    = 16'h002A;
    mem_cdr    = 16'h0000;

    // Single port-0 read, done two cycles after enable.
    vecs.push_back(row(1, 16'h0010, 0, 16'h0000, 0, 8'b1000_0000, 16'h0000));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 8'b0000_1100, 16'h0010));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 8'b0000_0100, 16'h0010));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 1, 8'b0000_0100, 16'h0010));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 8'b0010_0100, 16'h0010));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 8'b0000_0000, 16'h0010));
    // Port 1 alone, done already high in ISSUE: 2-cycle accept-to-response.
    vecs.push_back(row(0, 16'h0000, 1, 16'h0200, 0, 8'b0100_0000, 16'h0010));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 1, 8'b0000_1110, 16'h0200));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 8'b0001_0110, 16'h0200));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 8'b0000_0010, 16'h0200));
    // Both ports requesting continuously: grants alternate 0,1.
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 0, 8'b1000_0010, 16'h0200));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 1, 8'b0000_1100, 16'h0100));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 0, 8'b0010_0100, 16'h0100));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 0, 8'b0100_0000, 16'h0100));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 1, 8'b0000_1110, 16'h0200));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 0, 8'b0001_0110, 16'h0200));
    // Port 1 arrives during port 0's WAIT; done on the 4th (last legal) WAIT cycle.
    vecs.push_back(row(1, 16'h0100, 0, 16'h0200, 0, 8'b1000_0010, 16'h0200));
    vecs.push_back(row(1, 16'h0100, 0, 16'h0200, 0, 8'b0000_1100, 16'h0100));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 0, 8'b0000_0100, 16'h0100));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 0, 8'b0000_0100, 16'h0100));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 0, 8'b0000_0100, 16'h0100));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 1, 8'b0000_0100, 16'h0100));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 0, 8'b0010_0100, 16'h0100));
    vecs.push_back(row(1, 16'h0100, 1, 16'h0200, 0, 8'b0100_0000, 16'h0100));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 1, 8'b0000_1110, 16'h0200));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 8'b0001_0110, 16'h0200));
    vecs.push_back(row(0, 16'h0000, 0, 16'h0000, 0, 8'b0000_0010, 16'h0200));

    #1;
    chk("reset_outputs", 24'h000000);
    chk16("reset_rsp_car", rsp_car, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r0v, vecs[i].r0a, vecs[i].r1v, vecs[i].r1a, vecs[i].done);
      #1;
      chk($sformatf("vec%0d", i), {vecs[i].flags, vecs[i].addr});
    end
    chk16("table_rsp_header", rsp_header, 16'h0001);
    chk16("table_rsp_car", rsp_car, 16'h002A);
    chk16("table_rsp_cdr", rsp_cdr, 16'h0000);

    // Timeout: done never arrives, ERROR on the edge after WAIT cycle 4.
    step("to_accept", 1, 16'h0033, 0, 16'h0000, 0, 8'b1000_0010, 16'h0200);
    step("to_issue",  0, 16'h0000, 0, 16'h0000, 0, 8'b0000_1100, 16'h0033);
    for (int i = 1; i <= 4; i++)
      step($sformatf("to_wait%0d", i), 0, 16'h0000, 0, 16'h0000, 0, 8'b0000_0100, 16'h0033);
    step("to_error",  1, 16'h0050, 1, 16'h0060, 0, 8'b0000_0101, 16'h0033);
    step("err_hold1", 1, 16'h0050, 1, 16'h0060, 1, 8'b0000_0101, 16'h0033);
    step("err_hold2", 1, 16'h0050, 1, 16'h0060, 1, 8'b0000_0101, 16'h0033);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("err_reset", 24'h000000);
    chk16("err_reset_rsp_header", rsp_header, 16'h0000);
    chk16("err_reset_rsp_car", rsp_car, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT: abandoned with no response, then port 0 wins a tie.
    step("rw_accept", 1, 16'h0044, 0, 16'h0000, 0, 8'b1000_0000, 16'h0000);
    step("rw_issue",  0, 16'h0000, 0, 16'h0000, 0, 8'b0000_1100, 16'h0044);
    step("rw_wait",   0, 16'h0000, 0, 16'h0000, 0, 8'b0000_0100, 16'h0044);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_reset_immediate", 24'h000000);
    step("rw_reset_held", 0, 16'h0000, 0, 16'h0000, 1, 8'b0000_0000, 16'h0000);
    rst_n = 1'b1;
    mem_header = 16'h8005;
    mem_car    = 16'h1234;
    mem_cdr    = 16'hBEEF;
    step("rw_tie",   1, 16'h0100, 1, 16'h0200, 0, 8'b1000_0000, 16'h0000);
    step("rw_issue2", 0, 16'h0000, 0, 16'h0000, 1, 8'b0000_1100, 16'h0100);
    step("rw_resp",  0, 16'h0000, 0, 16'h0000, 0, 8'b0010_0100, 16'h0100);
    chk16("rw_rsp_header", rsp_header, 16'h8005);
    chk16("rw_rsp_car", rsp_car, 16'h1234);
    chk16("rw_rsp_cdr", rsp_cdr, 16'hBEEF);
    mem_header = 16'hFFFF;
    mem_car    = 16'hFFFF;
    mem_cdr    = 16'hFFFF;
    step("rw_idle",  0, 16'h0000, 0, 16'h0000, 1, 8'b0000_0000, 16'h0100);
    chk16("rw_hold_car", rsp_car, 16'h1234);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
